if_fetch_queue: RTL and testbench
=================================

IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: fetch queue entries, power of two, minimum 2.
REQ-002 SHALL have parameter ADDR_W, default 8: instruction-memory word-address width.
REQ-003 SHALL have parameter RESET_PC, default 32'h0: first fetched word address.
REQ-004 SHALL have port clk, input, 1: clock; all state changes on the rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port imem_req, output, 1: fetch request issued this cycle.
REQ-007 SHALL have port imem_addr, output, ADDR_W: word address, equal to pc[ADDR_W-1:0].
REQ-008 SHALL have port imem_rdata, input, 32: instruction word, valid exactly one cycle after imem_req.
REQ-009 SHALL have port redir_jmp, input, 1: jump redirect from ID.
REQ-010 SHALL have port redir_jmp_pc, input, 32: jump target.
REQ-011 SHALL have port redir_br, input, 1: taken-branch redirect.
REQ-012 SHALL have port redir_br_pc, input, 32: branch target.
REQ-013 SHALL have port id_ready, input, 1: ID accepts an instruction this cycle; deasserted means stall.
REQ-014 SHALL have port if_valid, output, 1: if_inst/if_pc/if_pc1 hold a real instruction.
REQ-015 SHALL have port if_inst, output, 32: head instruction; 0 (NOP) whenever if_valid=0.
REQ-016 SHALL have port if_pc, output, 32: word address of if_inst.
REQ-017 SHALL have port if_pc1, output, 32: if_pc+1.
REQ-018 SHALL have port if_ins_type, output, 4: instruction class of if_inst.

Function
REQ-019 SHALL use word addressing: sequential pc advances by 1, wrapping modulo 2^32.
REQ-020 SHALL assert imem_req only when (queue count + requests in flight) < DEPTH and no redirect is present this cycle; pc SHALL advance on each issued request.
REQ-021 SHALL write imem_rdata and its pc into the queue in the cycle after the request, unless that request was squashed.
REQ-022 SHALL give a fetch-to-valid latency of 2 edges: request at edge N, entry written at N+1, if_valid visible after N+1.
REQ-023 SHALL pop the head when if_valid and id_ready are both high; simultaneous push and pop SHALL keep count unchanged.
REQ-024 SHALL sustain one instruction per cycle when id_ready is held high and no redirect occurs.
REQ-025 SHALL never push when full and never pop when empty; if_valid=0 when the queue is empty.
REQ-026 SHALL, on a redirect, flush all queue entries, squash the in-flight response, load pc with the target at that edge, and issue the target fetch on the next cycle.
REQ-027 SHALL give redir_jmp priority over redir_br when both are asserted.
REQ-028 SHALL let a redirect win over a coincident pop and a coincident push; if_valid SHALL be 0 on the cycle after the redirect edge.
REQ-029 SHALL keep redirects effective while id_ready=0.

Reset
REQ-030 SHALL, on rst, set pc=RESET_PC, set queue count=0, clear in-flight/squash state, and drive if_valid=0, if_inst=0, if_pc=0, if_pc1=0, if_ins_type=INST_TYPE_NONE and imem_req=0.
REQ-031 SHALL discard any response arriving after a reset asserted mid-fetch.
REQ-032 SHALL issue the first request in the first cycle after rst deasserts.

Configuration
REQ-033 SHALL, when IF_FETCH_INST_TYPE_EN is defined, decode if_ins_type combinationally from if_inst (R-type funct ADD/SUB/AND/OR/NOR/SLT/SLL/SRL/SRA; ADDI/ANDI/ORI/LW/SW/BEQ/BNE/JMP), with unknown encodings or if_valid=0 giving INST_TYPE_NONE.
REQ-034 SHALL, when IF_FETCH_INST_TYPE_EN is not defined, tie if_ins_type to INST_TYPE_NONE and generate no decoder logic.

Structure
REQ-035 SHALL take OP_*, FUNC_* and INST_TYPE_* constants from the shared macro.vh; no local redefinition.
REQ-036 SHALL implement the queue as sub-module if_fifo (parameters DEPTH and width 64, storing {pc, inst}, with push/pop/flush and count), and keep pc/request/squash control in the parent.

Verification
REQ-037 SHALL cover reset release with id_ready=1 and memory word n = n: imem_addr runs 0,1,2,...; if_valid rises after the 2nd edge, if_pc=0, if_inst=0, then one instruction per cycle.
REQ-038 SHALL cover id_ready=0 held for 10 cycles with DEPTH=4: exactly 4 entries buffered, imem_req low once full, and on release pcs 0..3 delivered in order with no gap or duplicate.
REQ-039 SHALL cover redir_br=1 with redir_br_pc=32'h40 while a fetch is in flight: next if_valid instruction has if_pc=32'h40; no older pc appears after the redirect.
REQ-040 SHALL cover redir_jmp (target 32'h80) and redir_br (target 32'h40) in the same cycle: the stream resumes at 32'h80.
REQ-041 SHALL cover rst asserted mid-stream with a full queue: outputs zero immediately; after release, fetch restarts at RESET_PC.
REQ-042 SHALL cover pc=32'hFFFFFFFF sequential fetch: next if_pc=0 and if_pc1 wraps correctly; with the macro defined, an ADDI word gives if_ins_type=INST_TYPE_ADD.

Source files
------------

// File: rtl/if_fetch_queue_pkg.sv
// Shared constants for the instruction-fetch front end: opcode/funct
// encodings, instruction classes, the queue entry layout and the class decoder.
package if_fetch_queue_pkg;

  // Primary opcodes (inst[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_JMP   = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes (inst[5:0])
  localparam logic [5:0] FUNC_SLL = 6'b000000;
  localparam logic [5:0] FUNC_SRL = 6'b000010;
  localparam logic [5:0] FUNC_SRA = 6'b000011;
  localparam logic [5:0] FUNC_ADD = 6'b100000;
  localparam logic [5:0] FUNC_SUB = 6'b100010;
  localparam logic [5:0] FUNC_AND = 6'b100100;
  localparam logic [5:0] FUNC_OR  = 6'b100101;
  localparam logic [5:0] FUNC_NOR = 6'b100111;
  localparam logic [5:0] FUNC_SLT = 6'b101010;

  // Instruction classes; immediate ALU forms share the class of their R-type twin
  localparam logic [3:0] INST_TYPE_NONE = 4'd0;
  localparam logic [3:0] INST_TYPE_ADD  = 4'd1;
  localparam logic [3:0] INST_TYPE_SUB  = 4'd2;
  localparam logic [3:0] INST_TYPE_AND  = 4'd3;
  localparam logic [3:0] INST_TYPE_OR   = 4'd4;
  localparam logic [3:0] INST_TYPE_NOR  = 4'd5;
  localparam logic [3:0] INST_TYPE_SLT  = 4'd6;
  localparam logic [3:0] INST_TYPE_SLL  = 4'd7;
  localparam logic [3:0] INST_TYPE_SRL  = 4'd8;
  localparam logic [3:0] INST_TYPE_SRA  = 4'd9;
  localparam logic [3:0] INST_TYPE_LW   = 4'd10;
  localparam logic [3:0] INST_TYPE_SW   = 4'd11;
  localparam logic [3:0] INST_TYPE_BEQ  = 4'd12;
  localparam logic [3:0] INST_TYPE_BNE  = 4'd13;
  localparam logic [3:0] INST_TYPE_JMP  = 4'd14;

  // One queue entry: the word address travels with its instruction
  localparam int FETCH_ENTRY_W = 64;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Map an instruction word to its class; anything unrecognised is NONE
  function automatic logic [3:0] decode_ins_type(input logic [31:0] inst);
    logic [3:0] t;
    t = INST_TYPE_NONE;
    case (inst[31:26])
      OP_RTYPE: begin
        case (inst[5:0])
          FUNC_ADD: t = INST_TYPE_ADD;
          FUNC_SUB: t = INST_TYPE_SUB;
          FUNC_AND: t = INST_TYPE_AND;
          FUNC_OR:  t = INST_TYPE_OR;
          FUNC_NOR: t = INST_TYPE_NOR;
          FUNC_SLT: t = INST_TYPE_SLT;
          FUNC_SLL: t = INST_TYPE_SLL;
          FUNC_SRL: t = INST_TYPE_SRL;
          FUNC_SRA: t = INST_TYPE_SRA;
          default:  t = INST_TYPE_NONE;
        endcase
      end
      OP_ADDI: t = INST_TYPE_ADD;
      OP_ANDI: t = INST_TYPE_AND;
      OP_ORI:  t = INST_TYPE_OR;
      OP_LW:   t = INST_TYPE_LW;
      OP_SW:   t = INST_TYPE_SW;
      OP_BEQ:  t = INST_TYPE_BEQ;
      OP_BNE:  t = INST_TYPE_BNE;
      OP_JMP:  t = INST_TYPE_JMP;
      default: t = INST_TYPE_NONE;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/if_fetch_queue_fifo.sv
// if_fifo: small first-word-fall-through queue with flush. The head entry is
// read combinationally so a freshly written entry is visible right after the
// edge that wrote it. Push is ignored when full, pop when empty; flush wins
// over both.
module if_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign dout    = mem[rd_ptr_reg];
  assign count   = count_reg;

  // Storage write; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= din;
  end

  // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction fetch with a small prefetch queue.
// The parent owns the pc, request issue and squashing of in-flight responses;
// storage lives in if_fifo. Memory answers exactly one cycle after a request.
// Optional build macro IF_FETCH_INST_TYPE_EN enables the if_ins_type decoder;
// without it if_ins_type is tied to INST_TYPE_NONE.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              redir_jmp,
  input  logic [31:0]       redir_jmp_pc,
  input  logic              redir_br,
  input  logic [31:0]       redir_br_pc,
  input  logic              id_ready,
  output logic              if_valid,
  output logic [31:0]       if_inst,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_pc1,
  output logic [3:0]        if_ins_type
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [31:0]      pc_reg;
  logic [31:0]      pc_next;
  logic             inflight_reg;
  logic [31:0]      inflight_pc_reg;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   occupancy;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  fetch_entry_t     fifo_din;
  fetch_entry_t     fifo_dout;

  // Jump outranks branch when both arrive together
  assign redirect    = redir_jmp || redir_br;
  assign redirect_pc = redir_jmp ? redir_jmp_pc : redir_br_pc;

  // Requests already in flight count against capacity so a response always has room
  assign occupancy = {1'b0, fifo_count} + (CNT_W+1)'(inflight_reg);
  assign imem_req  = !rst && !redirect && (occupancy < (CNT_W+1)'(DEPTH));
  assign imem_addr = pc_reg[ADDR_W-1:0];

  // A redirect drops the response of the previous request instead of pushing it
  assign fifo_push     = inflight_reg && !redirect;
  assign fifo_pop      = if_valid && id_ready && !redirect;
  assign fifo_din.pc   = inflight_pc_reg;
  assign fifo_din.inst = imem_rdata;

  // Next pc: redirect target, else advance on every issued request (wraps mod 2^32)
  always_comb begin
    pc_next = pc_reg;
    if (redirect)      pc_next = redirect_pc;
    else if (imem_req) pc_next = pc_reg + 32'd1;
  end

  // pc and in-flight tracking; reset also forgets any response still on its way
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg          <= RESET_PC;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= 32'h0;
    end else begin
      pc_reg          <= pc_next;
      inflight_reg    <= imem_req;
      inflight_pc_reg <= pc_reg;
    end
  end

  if_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FETCH_ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (redirect),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  // Head presentation; an empty queue shows a NOP at address zero
  assign if_valid = !fifo_empty;
  assign if_inst  = if_valid ? fifo_dout.inst : 32'h0;
  assign if_pc    = if_valid ? fifo_dout.pc : 32'h0;
  assign if_pc1   = if_valid ? fifo_dout.pc + 32'd1 : 32'h0;

`ifdef IF_FETCH_INST_TYPE_EN
  // Classify the head instruction; NONE whenever nothing valid is presented
  always_comb begin
    if_ins_type = INST_TYPE_NONE;
    if (if_valid) if_ins_type = decode_ins_type(if_inst);
  end
`else
  assign if_ins_type = INST_TYPE_NONE;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: reset, streaming, stall fill, redirects,
// pc wrap and mid-stream reset. Memory word at address a is a, except address
// 8'hFF which holds an ADDI word.
module tb_if_fetch_queue;
  import if_fetch_queue_pkg::*;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        redir_jmp;
  logic [31:0] redir_jmp_pc;
  logic        redir_br;
  logic [31:0] redir_br_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] if_pc1;
  logic [3:0]  if_ins_type;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] ADDI_WORD = 32'h2001_0005;

`ifdef IF_FETCH_INST_TYPE_EN
  localparam logic [3:0] EXP_ADDI_TYPE = INST_TYPE_ADD;
`else
  localparam logic [3:0] EXP_ADDI_TYPE = INST_TYPE_NONE;
`endif

  if_fetch_queue #(
    .DEPTH    (4),
    .ADDR_W   (8),
    .RESET_PC (32'h0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .redir_jmp    (redir_jmp),
    .redir_jmp_pc (redir_jmp_pc),
    .redir_br     (redir_br),
    .redir_br_pc  (redir_br_pc),
    .id_ready     (id_ready),
    .if_valid     (if_valid),
    .if_inst      (if_inst),
    .if_pc        (if_pc),
    .if_pc1       (if_pc1),
    .if_ins_type  (if_ins_type)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: one-cycle registered read
  initial imem_rdata = 32'h0;
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= (imem_addr == 8'hFF) ? ADDI_WORD : {24'h0, imem_addr};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; id_ready = 1'b1;
    redir_jmp = 1'b0; redir_jmp_pc = 32'h0;
    redir_br = 1'b0; redir_br_pc = 32'h0;
    repeat (2) step();

    // Reset state
    check("rst_valid", {31'h0, if_valid}, 32'd0);
    check("rst_inst", if_inst, 32'h0);
    check("rst_pc", if_pc, 32'h0);
    check("rst_pc1", if_pc1, 32'h0);
    check("rst_type", {28'h0, if_ins_type}, {28'h0, INST_TYPE_NONE});
    check("rst_req", {31'h0, imem_req}, 32'd0);

    // Release: first request in the first cycle
    rst = 1'b0; #1;
    check("first_req", {31'h0, imem_req}, 32'd1);
    check("first_addr", {24'h0, imem_addr}, 32'h0);
    step();
    check("lat_valid0", {31'h0, if_valid}, 32'd0);
    check("addr1", {24'h0, imem_addr}, 32'h1);
    step();
    // Streaming, one instruction per cycle
    for (int k = 0; k < 5; k++) begin
      check($sformatf("strm_valid%0d", k), {31'h0, if_valid}, 32'd1);
      check($sformatf("strm_pc%0d", k), if_pc, 32'(k));
      check($sformatf("strm_inst%0d", k), if_inst, 32'(k));
      check($sformatf("strm_pc1_%0d", k), if_pc1, 32'(k + 1));
      if (k < 4) step();
    end

    // Stall for 10 cycles: queue fills to 4 (pcs 4..7), requests stop
    id_ready = 1'b0;
    repeat (10) step();
    check("stall_req", {31'h0, imem_req}, 32'd0);
    check("stall_valid", {31'h0, if_valid}, 32'd1);
    check("stall_head", if_pc, 32'd4);
    id_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("rel_valid%0d", i), {31'h0, if_valid}, 32'd1);
      check($sformatf("rel_pc%0d", i), if_pc, 32'(4 + i));
      check($sformatf("rel_inst%0d", i), if_inst, 32'(4 + i));
      step();
    end

    // Branch redirect while a fetch is in flight
    redir_br = 1'b1; redir_br_pc = 32'h40; #1;
    check("br_req_blocked", {31'h0, imem_req}, 32'd0);
    step();
    redir_br = 1'b0;
    check("br_flush_valid", {31'h0, if_valid}, 32'd0);
    #1;
    check("br_req", {31'h0, imem_req}, 32'd1);
    check("br_addr", {24'h0, imem_addr}, 32'h40);
    step();
    check("br_lat_valid", {31'h0, if_valid}, 32'd0);
    step();
    check("br_valid", {31'h0, if_valid}, 32'd1);
    check("br_pc", if_pc, 32'h40);
    check("br_inst", if_inst, 32'h40);
    step();
    check("br_pc_next", if_pc, 32'h41);

    // Jump and branch together: jump wins
    redir_jmp = 1'b1; redir_jmp_pc = 32'h80;
    redir_br = 1'b1; redir_br_pc = 32'h40;
    step();
    redir_jmp = 1'b0; redir_br = 1'b0;
    check("jb_flush_valid", {31'h0, if_valid}, 32'd0);
    #1;
    check("jb_addr", {24'h0, imem_addr}, 32'h80);
    repeat (2) step();
    check("jb_pc", if_pc, 32'h80);
    check("jb_inst", if_inst, 32'h80);
    step();
    check("jb_pc_next", if_pc, 32'h81);

    // pc wrap from 32'hFFFFFFFF
    redir_jmp = 1'b1; redir_jmp_pc = 32'hFFFF_FFFF;
    step();
    redir_jmp = 1'b0; #1;
    check("wrap_addr", {24'h0, imem_addr}, 32'hFF);
    repeat (2) step();
    check("wrap_pc", if_pc, 32'hFFFF_FFFF);
    check("wrap_pc1", if_pc1, 32'h0);
    check("wrap_inst", if_inst, ADDI_WORD);
    check("wrap_type", {28'h0, if_ins_type}, {28'h0, EXP_ADDI_TYPE});
    step();
    check("wrap_next_pc", if_pc, 32'h0);
    check("wrap_next_pc1", if_pc1, 32'h1);
    check("wrap_next_inst", if_inst, 32'h0);

    // Fill the queue, then reset mid-stream
    id_ready = 1'b0;
    repeat (6) step();
    check("full_req", {31'h0, imem_req}, 32'd0);
    check("full_head", if_pc, 32'h0);
    #2;
    rst = 1'b1; #1;
    check("mrst_valid", {31'h0, if_valid}, 32'd0);
    check("mrst_pc", if_pc, 32'h0);
    check("mrst_pc1", if_pc1, 32'h0);
    check("mrst_inst", if_inst, 32'h0);
    check("mrst_req", {31'h0, imem_req}, 32'd0);
    repeat (2) step();
    rst = 1'b0; id_ready = 1'b1; #1;
    check("mrst_restart_req", {31'h0, imem_req}, 32'd1);
    check("mrst_restart_addr", {24'h0, imem_addr}, 32'h0);
    step();
    check("mrst_lat_valid", {31'h0, if_valid}, 32'd0);
    step();
    check("mrst_pc0", if_pc, 32'h0);
    check("mrst_valid1", {31'h0, if_valid}, 32'd1);
    step();
    check("mrst_pc1_stream", if_pc, 32'h1);

    // Redirect while ID is stalled still takes effect
    id_ready = 1'b0;
    redir_br = 1'b1; redir_br_pc = 32'h20;
    step();
    redir_br = 1'b0; #1;
    check("stl_br_valid", {31'h0, if_valid}, 32'd0);
    check("stl_br_addr", {24'h0, imem_addr}, 32'h20);
    repeat (2) step();
    check("stl_br_pc", if_pc, 32'h20);
    step();
    check("stl_br_hold", if_pc, 32'h20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
